// File: rtl/ptw_req_arbiter.sv
// ptw_req_arbiter
//   Shares one page-table walker between the instruction-TLB (imem) and the
//   data-TLB (dmem). Requests are granted round-robin, only one walk is in
//   flight at a time, and the walker response is steered back to the
//   requester that owns the walk. A walk that sees no response within
//   TIMEOUT cycles is completed with an error. The late walker response is
//   then drained silently.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   io_imem_req_*              imem walk request (valid/ready/vpn)
//   io_dmem_req_*              dmem walk request (valid/ready/vpn)
//   io_ptw_req_*               request to the walker (valid/ready/vpn)
//   io_ptw_resp_*              walker response (valid/error/ppn), no backpressure
//   io_imem_resp_*             registered 1-cycle response to imem
//   io_dmem_resp_*             registered 1-cycle response to dmem
//   io_busy                    a walk is in progress (state != IDLE)
//   io_spurious                1-cycle pulse: a walker response arrived while
//                              no walk was waiting for one
module ptw_req_arbiter #(
    parameter int VPN_W   = 20,
    parameter int PPN_W   = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_imem_req_valid,
    output logic             io_imem_req_ready,
    input  logic [VPN_W-1:0] io_imem_req_bits_vpn,
    input  logic             io_dmem_req_valid,
    output logic             io_dmem_req_ready,
    input  logic [VPN_W-1:0] io_dmem_req_bits_vpn,
    output logic             io_ptw_req_valid,
    input  logic             io_ptw_req_ready,
    output logic [VPN_W-1:0] io_ptw_req_bits_vpn,
    input  logic             io_ptw_resp_valid,
    input  logic             io_ptw_resp_bits_error,
    input  logic [PPN_W-1:0] io_ptw_resp_bits_ppn,
    output logic             io_imem_resp_valid,
    output logic             io_imem_resp_bits_error,
    output logic [PPN_W-1:0] io_imem_resp_bits_ppn,
    output logic             io_dmem_resp_valid,
    output logic             io_dmem_resp_bits_error,
    output logic [PPN_W-1:0] io_dmem_resp_bits_ppn,
    output logic             io_busy,
    output logic             io_spurious
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    state_t             state;
    logic               owner;       // 0 = imem, 1 = dmem
    logic               last_grant;  // requester granted most recently
    logic [VPN_W-1:0]   vpn_q;
    logic [CNT_W-1:0]   cnt;
    logic               grant_i;
    logic               grant_d;

    // Round-robin: a lone requester always wins; on a tie the requester
    // that was not granted last time wins.
    always_comb begin
        grant_i = io_imem_req_valid && (!io_dmem_req_valid || last_grant);
        grant_d = io_dmem_req_valid && (!io_imem_req_valid || !last_grant);
    end

    assign io_imem_req_ready   = (state == IDLE) && grant_i;
    assign io_dmem_req_ready   = (state == IDLE) && grant_d;
    assign io_ptw_req_valid    = (state == ISSUE);
    assign io_ptw_req_bits_vpn = vpn_q;
    assign io_busy             = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= IDLE;
            owner                   <= 1'b0;
            last_grant              <= 1'b1;
            vpn_q                   <= '0;
            cnt                     <= '0;
            io_imem_resp_valid      <= 1'b0;
            io_imem_resp_bits_error <= 1'b0;
            io_imem_resp_bits_ppn   <= '0;
            io_dmem_resp_valid      <= 1'b0;
            io_dmem_resp_bits_error <= 1'b0;
            io_dmem_resp_bits_ppn   <= '0;
            io_spurious             <= 1'b0;
        end else begin
            // Pulses default low; resp_bits keep their last value.
            io_imem_resp_valid <= 1'b0;
            io_dmem_resp_valid <= 1'b0;
            io_spurious        <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_ptw_resp_valid) io_spurious <= 1'b1;
                    if (grant_i || grant_d) begin
                        owner      <= grant_d;
                        last_grant <= grant_d;
                        vpn_q      <= grant_d ? io_dmem_req_bits_vpn : io_imem_req_bits_vpn;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (io_ptw_resp_valid) io_spurious <= 1'b1;
                    if (io_ptw_req_ready) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A response in the timeout cycle still counts as a
                    // normal completion.
                    if (io_ptw_resp_valid) begin
                        if (owner) begin
                            io_dmem_resp_valid      <= 1'b1;
                            io_dmem_resp_bits_error <= io_ptw_resp_bits_error;
                            io_dmem_resp_bits_ppn   <= io_ptw_resp_bits_ppn;
                        end else begin
                            io_imem_resp_valid      <= 1'b1;
                            io_imem_resp_bits_error <= io_ptw_resp_bits_error;
                            io_imem_resp_bits_ppn   <= io_ptw_resp_bits_ppn;
                        end
                        state <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        if (owner) begin
                            io_dmem_resp_valid      <= 1'b1;
                            io_dmem_resp_bits_error <= 1'b1;
                            io_dmem_resp_bits_ppn   <= '0;
                        end else begin
                            io_imem_resp_valid      <= 1'b1;
                            io_imem_resp_bits_error <= 1'b1;
                            io_imem_resp_bits_ppn   <= '0;
                        end
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (io_ptw_resp_valid) io_spurious <= 1'b1;
                    state <= IDLE;
                end
                DRAIN: begin
                    // The walker still owes a response to the timed-out walk;
                    // swallow it so it is not mistaken for a later walk's.
                    if (io_ptw_resp_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ptw_req_arbiter.sv
module tb_ptw_req_arbiter;

    localparam int VPN_W = 20;
    localparam int PPN_W = 32;
    localparam int TO    = 4;

    localparam logic [1:0] K_IMEM = 2'd0;
    localparam logic [1:0] K_DMEM = 2'd1;
    localparam logic [1:0] K_SPUR = 2'd2;

    typedef struct {
        logic [1:0]       kind;
        logic             err;
        logic [PPN_W-1:0] ppn;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             imem_req_valid, imem_req_ready;
    logic [VPN_W-1:0] imem_req_vpn;
    logic             dmem_req_valid, dmem_req_ready;
    logic [VPN_W-1:0] dmem_req_vpn;
    logic             ptw_req_valid, ptw_req_ready;
    logic [VPN_W-1:0] ptw_req_vpn;
    logic             ptw_resp_valid, ptw_resp_err;
    logic [PPN_W-1:0] ptw_resp_ppn;
    logic             imem_resp_valid, imem_resp_err;
    logic [PPN_W-1:0] imem_resp_ppn;
    logic             dmem_resp_valid, dmem_resp_err;
    logic [PPN_W-1:0] dmem_resp_ppn;
    logic             busy, spurious;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    ptw_req_arbiter #(.VPN_W(VPN_W), .PPN_W(PPN_W), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .io_imem_req_valid      (imem_req_valid),
        .io_imem_req_ready      (imem_req_ready),
        .io_imem_req_bits_vpn   (imem_req_vpn),
        .io_dmem_req_valid      (dmem_req_valid),
        .io_dmem_req_ready      (dmem_req_ready),
        .io_dmem_req_bits_vpn   (dmem_req_vpn),
        .io_ptw_req_valid       (ptw_req_valid),
        .io_ptw_req_ready       (ptw_req_ready),
        .io_ptw_req_bits_vpn    (ptw_req_vpn),
        .io_ptw_resp_valid      (ptw_resp_valid),
        .io_ptw_resp_bits_error (ptw_resp_err),
        .io_ptw_resp_bits_ppn   (ptw_resp_ppn),
        .io_imem_resp_valid     (imem_resp_valid),
        .io_imem_resp_bits_error(imem_resp_err),
        .io_imem_resp_bits_ppn  (imem_resp_ppn),
        .io_dmem_resp_valid     (dmem_resp_valid),
        .io_dmem_resp_bits_error(dmem_resp_err),
        .io_dmem_resp_bits_ppn  (dmem_resp_ppn),
        .io_busy                (busy),
        .io_spurious            (spurious)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic err, input logic [PPN_W-1:0] ppn);
        exp_t e;
        e.kind = kind; e.err = err; e.ppn = ppn;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input logic [1:0] kind, input logic err, input logic [PPN_W-1:0] ppn);
        exp_t e;
        n_chk++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind=%0d err=%0d ppn=%h, expected no event", kind, err, ppn);
        end else begin
            e = sbq.pop_front();
            if (e.kind !== kind || e.err !== err || e.ppn !== ppn) begin
                n_fail++;
                $display("FAIL sb_event: got kind=%0d err=%0d ppn=%h expected kind=%0d err=%0d ppn=%h",
                         kind, err, ppn, e.kind, e.err, e.ppn);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_resp_valid && dmem_resp_valid) begin
                n_chk++;
                n_fail++;
                $display("FAIL both_resp_valid: got 1/1 expected at most one");
            end
            if (imem_resp_valid) sb_pop(K_IMEM, imem_resp_err, imem_resp_ppn);
            if (dmem_resp_valid) sb_pop(K_DMEM, dmem_resp_err, dmem_resp_ppn);
            if (spurious)        sb_pop(K_SPUR, 1'b0, '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete walk. Starts in IDLE, ends in IDLE (or DRAIN if no resp).
    task automatic run_walk(input logic iv, input logic dv,
                            input logic [VPN_W-1:0] ivpn, input logic [VPN_W-1:0] dvpn,
                            input bit exp_d, input bit hold, input int rdy_delay,
                            input int wait_cyc, input bit do_resp,
                            input logic err, input logic [PPN_W-1:0] ppn);
        logic [VPN_W-1:0] evpn;
        evpn = exp_d ? dvpn : ivpn;
        imem_req_valid = iv; imem_req_vpn = ivpn;
        dmem_req_valid = dv; dmem_req_vpn = dvpn;
        #1;
        chk("imem_req_ready", 64'(imem_req_ready), 64'(!exp_d));
        chk("dmem_req_ready", 64'(dmem_req_ready), 64'(exp_d));
        step();                                   // grant -> ISSUE
        if (!hold) begin imem_req_valid = 1'b0; dmem_req_valid = 1'b0; end
        ptw_req_ready = 1'b0;
        chk("issue_valid", 64'(ptw_req_valid), 64'd1);
        chk("issue_vpn", 64'(ptw_req_vpn), 64'(evpn));
        chk("issue_req_ready_low", 64'({imem_req_ready, dmem_req_ready}), 64'd0);
        for (int i = 0; i < rdy_delay; i++) begin
            step();
            chk("stall_valid", 64'(ptw_req_valid), 64'd1);
            chk("stall_vpn", 64'(ptw_req_vpn), 64'(evpn));
        end
        ptw_req_ready = 1'b1;
        step();                                   // handshake -> WAIT, cnt=0
        ptw_req_ready = 1'b0;
        chk("wait_valid_low", 64'(ptw_req_valid), 64'd0);
        if (do_resp) begin
            for (int i = 0; i < wait_cyc; i++) step();
            ptw_resp_valid = 1'b1; ptw_resp_err = err; ptw_resp_ppn = ppn;
            expect_ev(exp_d ? K_DMEM : K_IMEM, err, ppn);
            step();                               // -> RESP
            ptw_resp_valid = 1'b0; ptw_resp_err = 1'b0; ptw_resp_ppn = '0;
            chk("resp_busy", 64'(busy), 64'd1);
            step();                               // -> IDLE
            chk("idle_busy", 64'(busy), 64'd0);
        end else begin
            expect_ev(exp_d ? K_DMEM : K_IMEM, 1'b1, '0);
            for (int i = 0; i < TO + 1; i++) step();  // cnt 0..TO, fires at TO
            chk("drain_busy", 64'(busy), 64'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        imem_req_valid = 1'b0; imem_req_vpn = '0;
        dmem_req_valid = 1'b0; dmem_req_vpn = '0;
        ptw_req_ready = 1'b0;
        ptw_resp_valid = 1'b0; ptw_resp_err = 1'b0; ptw_resp_ppn = '0;
        step(); step();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ptw_req_valid", 64'(ptw_req_valid), 64'd0);
        chk("rst_resp_valid", 64'({imem_resp_valid, dmem_resp_valid, spurious}), 64'd0);
        chk("rst_resp_bits", 64'({imem_resp_err, imem_resp_ppn}), 64'd0);
        chk("rst_dmem_bits", 64'({dmem_resp_err, dmem_resp_ppn}), 64'd0);

        // Both requesting continuously: imem, dmem, imem, dmem
        run_walk(1, 1, 20'h11111, 20'h22222, 0, 1, 0, 0, 1, 1'b0, 32'h0000_1000);
        run_walk(1, 1, 20'h11111, 20'h22222, 1, 1, 0, 1, 1, 1'b0, 32'h0000_2001);
        run_walk(1, 1, 20'h11111, 20'h22222, 0, 1, 0, 2, 1, 1'b1, 32'h0000_1002);
        run_walk(1, 1, 20'h11111, 20'h22222, 1, 1, 0, 0, 1, 1'b0, 32'h0000_2003);
        imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
        chk("hold_bits_dmem", 64'(dmem_resp_ppn), 64'h0000_2003);
        chk("hold_bits_imem", 64'({imem_resp_err, imem_resp_ppn}), 64'h1_0000_1002);

        // Single imem walk, response after 3 wait cycles
        run_walk(1, 0, 20'h12345, 20'h0, 0, 0, 0, 3, 1, 1'b0, 32'hABCD_0000);

        // Walker stalls ISSUE for 5 cycles; counter must not run meanwhile
        run_walk(0, 1, 20'h0, 20'h0BEEF, 1, 0, 5, 3, 1, 1'b0, 32'h0000_0BEE);

        // Timeout on a dmem walk, late response drained silently
        run_walk(0, 1, 20'h0, 20'h00AAA, 1, 0, 0, 0, 0, 1'b0, '0);
        step(); step();
        chk("drain_wait_busy", 64'(busy), 64'd1);
        ptw_resp_valid = 1'b1; ptw_resp_ppn = 32'h55;
        step();
        ptw_resp_valid = 1'b0; ptw_resp_ppn = '0;
        chk("drain_done_busy", 64'(busy), 64'd0);
        step(); step();

        // Response exactly at counter == TIMEOUT completes normally
        run_walk(1, 0, 20'h00777, 20'h0, 0, 0, 0, TO, 1, 1'b1, 32'h0000_0777);

        // Response while IDLE is spurious
        ptw_resp_valid = 1'b1; ptw_resp_ppn = 32'h99;
        expect_ev(K_SPUR, 1'b0, '0);
        step();
        ptw_resp_valid = 1'b0; ptw_resp_ppn = '0;
        chk("spur_busy", 64'(busy), 64'd0);
        step();

        // Reset in WAIT abandons the walk; late response is spurious only
        imem_req_valid = 1'b1; imem_req_vpn = 20'h0CAFE;
        step();
        imem_req_valid = 1'b0;
        ptw_req_ready = 1'b1;
        step();
        ptw_req_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_resp_valid", 64'({imem_resp_valid, dmem_resp_valid}), 64'd0);
        ptw_resp_valid = 1'b1; ptw_resp_ppn = 32'h1234;
        expect_ev(K_SPUR, 1'b0, '0);
        step();
        ptw_resp_valid = 1'b0; ptw_resp_ppn = '0;
        step(); step();

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
